// File: rtl/demux1to8_32bit_reg.sv
// Registered 1-to-8 demultiplexer for WIDTH-bit words with a valid/ready handshake
// on the input and a one-entry buffer per output lane; lanes stall independently.
module demux1to8_32bit_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:WIDTH-1] in,
    input  logic [0:2]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:WIDTH-1] out0,
    output logic [0:WIDTH-1] out1,
    output logic [0:WIDTH-1] out2,
    output logic [0:WIDTH-1] out3,
    output logic [0:WIDTH-1] out4,
    output logic [0:WIDTH-1] out5,
    output logic [0:WIDTH-1] out6,
    output logic [0:WIDTH-1] out7,
    output logic [0:7]       out_valid,
    input  logic [0:7]       out_ready,
    output logic [0:CNT_W-1] count
);

    logic [0:WIDTH-1] data_q [0:7];
    logic [0:WIDTH-1] data_d [0:7];
    logic [0:7]       valid_q;
    logic [0:7]       valid_d;
    logic [0:CNT_W-1] count_q;
    logic [0:CNT_W-1] count_d;
    logic             acc_s;

    // A full lane may refill in the cycle it drains, so ready looks at the lane's consumer too.
    always_comb begin
        in_ready = !reset && (!valid_q[sel] || out_ready[sel]);
        acc_s    = in_valid && in_ready;
    end

    // Per-lane next state: reset, then load (wins over drain), then drain, else hold.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            data_d[k]  = data_q[k];
            valid_d[k] = valid_q[k];
            if (reset) begin
                data_d[k]  = '0;
                valid_d[k] = 1'b0;
            end else if (acc_s && (sel == 3'(k))) begin
                data_d[k]  = in;
                valid_d[k] = 1'b1;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Accepted-word counter, wraps silently.
    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = '0;
        end else if (acc_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        data_q  <= data_d;
        valid_q <= valid_d;
        count_q <= count_d;
    end

    // Output wiring straight from the registers.
    always_comb begin
        out0      = data_q[0];
        out1      = data_q[1];
        out2      = data_q[2];
        out3      = data_q[3];
        out4      = data_q[4];
        out5      = data_q[5];
        out6      = data_q[6];
        out7      = data_q[7];
        out_valid = valid_q;
        count     = count_q;
    end

endmodule

// File: doc/demux1to8_32bit_reg.md
# demux1to8_32bit_reg

Registered 1-to-8 demultiplexer for 32-bit words with a valid/ready handshake on the input and on each of the eight output lanes. It is the write-side counterpart of the 8-to-1 32-bit mux in the ALU datapath. It routes one input word per cycle to the lane chosen by `sel` and holds the word in that lane's output register until the lane's consumer takes it. Each lane buffers one entry; lanes stall independently.

## Interface
Parameters:
- `WIDTH`, 32, data width of the input and of each lane.
- `CNT_W`, 16, width of the accepted-word counter.

Ports (vectors are MSB-first, `[0:WIDTH-1]`, bit 0 = MSB):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `in`  in  WIDTH  input word.
- `sel`  in  3  destination lane, 0..7.
- `in_valid`  in  1  `in` and `sel` are valid this cycle.
- `in_ready`  out  1  the block can accept the word for the currently presented `sel`.
- `out0`..`out7`  out  WIDTH  lane data registers.
- `out_valid`  out  8 `[0:7]`  lane k holds an undelivered word; bit k corresponds to `outk`.
- `out_ready`  in  8 `[0:7]`  consumer of lane k takes the word this cycle.
- `count`  out  CNT_W  number of accepted input words, modulo 2^CNT_W.

## Operation
- Accept: `acc = in_valid & in_ready`.
- Lane k drain: `drn[k] = out_valid[k] & out_ready[k]`.
- `in_ready = !reset & (!out_valid[sel] | out_ready[sel])`.
  - `in_ready` is combinational from `sel`, `out_valid` and `out_ready`.
  - A full lane accepts a new word in the same cycle it is drained (pass-through refill, no bubble).
- Lane k update, in priority order:
  - If `reset`: `outk <= 0`, `out_valid[k] <= 0`.
  - Else if `acc & (sel == k)`: `outk <= in`, `out_valid[k] <= 1`. Load wins over a simultaneous drain.
  - Else if `drn[k]`: `out_valid[k] <= 0`. `outk` keeps its last value; data is not cleared.
  - Else: hold.
- Only the selected lane changes on an accept; the other seven lanes are unaffected.
- Lanes drain independently. Any combination of `out_ready` bits may be high in one cycle.
- Counter:
  - `count <= count + 1` on every `acc`.
  - Wraps from 2^CNT_W−1 to 0 with no flag.
  - A stalled word (`in_valid & !in_ready`) is not counted.
- No protocol checking: `in_valid` may drop or `sel` may change while stalled; the block treats each cycle independently.
- `out_ready` on a lane with `out_valid[k]=0` has no effect.

## Timing
- Reset values: all `outk` = 0, `out_valid` = 8'b0, `count` = 0, `in_ready` = 0 while `reset` is high.
- Reset mid-operation clears all pending words: they are dropped and not delivered. An accept in the reset cycle is ignored.
- Latency:
  - Accept on edge N: word visible on `outk` with `out_valid[k]=1` after edge N.
  - Earliest drain is the cycle following edge N.
- Throughput:
  - One word per cycle to distinct lanes, or to the same lane if its consumer holds `out_ready[k]` high continuously.
  - A lane with `out_ready[k]` low blocks only inputs addressed to it.
- `count` reflects an accept on edge N from after edge N.

## Test plan
- Reset, then all `out_ready`=1 and `in_valid`=1. Drive `sel`=0..7 on consecutive cycles with `in`=32'h00000000, 32'h11111111 … 32'h77777777. Required: each `outk`=32'hkkkkkkkk with `out_valid[k]` high for exactly one cycle, one cycle after its accept; `count`=8 at the end.
- Fill and stall: `out_ready`=0. Write `sel`=3 with 32'hDEADBEEF, then `sel`=3 with 32'hCAFEF00D. Required: `in_ready`=0 on the second word; `out3` holds 32'hDEADBEEF; `count`=1. Raise `out_ready[3]` and the second word is accepted that cycle; `out3`=32'hCAFEF00D next cycle; `count`=2.
- Independence: lane 5 full and stalled. Writes to `sel`=2 (32'h22222222) and `sel`=6 (32'h66666666) are accepted on back-to-back cycles. `out_valid` = 8'b00100110 (bits 2, 5, 6 set) with all `out_ready` low.
- Simultaneous load and drain on lane 1: `out_valid[1]`=1, `out_ready[1]`=1, `in_valid`=1, `sel`=1, `in`=32'h12345678. Required: `in_ready`=1; next cycle `out1`=32'h12345678 and `out_valid[1]`=1.
- Drain keeps data: drain lane 4 holding 32'h44444444. Required: `out_valid[4]`=0 and `out4` still reads 32'h44444444.
- Reset mid-operation with lanes 0 and 7 valid and `count`=0x0005, with `in_valid`=1 during reset. Required: after the edge, `out_valid`=0, `out0`=`out7`=0, `count`=0, and `in_ready`=0 during reset. Separately, preload `count`=0xFFFF via 65535 accepts; the next accept gives `count`=0x0000.
